// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 transmit-only UART with TX FIFO
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        uart_tx,
  output logic        tx_empty_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     div_q, div_d, bit_div_q, bit_div_d, timer_q, timer_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            uart_tx_q, uart_tx_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic        push_req, accept, pop, status_wr, div_wr, full, empty, busy;
  logic [15:0] bit_div_new;
  logic [31:0] count_ext;
  logic [3:0]  count_sat;
  logic        unused_bits;

  assign unused_bits = ^{addr[1:0], write_data[31:16], byte_enable[3:2]};

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign push_req  = mem_write && hit && (addr[3:2] == 2'd0) && byte_enable[0];
  assign status_wr = mem_write && hit && (addr[3:2] == 2'd1) && byte_enable[0];
  assign div_wr    = mem_write && hit && (addr[3:2] == 2'd2) && (byte_enable[1:0] == 2'b11);

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign busy      = (state_q != ST_IDLE);
  assign count_ext = 32'(count_q);
  assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  assign uart_tx      = uart_tx_q;
  assign tx_empty_irq = empty && !busy;

  always_comb begin
    read_data = 32'h0;
    if (hit) begin
      case (addr[3:2])
        2'd1:    read_data = {24'h0, count_sat, overflow_q, busy, empty, full};
        2'd2:    read_data = {16'h0, div_q};
        default: read_data = 32'h0;
      endcase
    end
  end

  // Transmitter: a pop always (re)starts a frame, from IDLE or from the last STOP cycle.
  always_comb begin
    state_d     = state_q;
    bit_div_d   = bit_div_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rd_ptr_d    = rd_ptr_q;
    uart_tx_d   = 1'b1;
    pop         = 1'b0;
    bit_div_new = (div_q == 16'h0) ? 16'd1 : div_q;
    case (state_q)
      ST_IDLE: begin
        pop = !empty;
      end
      ST_START: begin
        uart_tx_d = 1'b0;
        if (timer_q == 16'h0) begin
          state_d   = ST_DATA;
          timer_d   = bit_div_q - 16'd1;
          bit_cnt_d = 3'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        uart_tx_d = shift_q[0];
        if (timer_q == 16'h0) begin
          shift_d   = {1'b0, shift_q[7:1]};
          timer_d   = bit_div_q - 16'd1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        if (timer_q == 16'h0) begin
          if (!empty) pop = 1'b1;
          else        state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
    endcase
    if (pop) begin
      state_d   = ST_START;
      shift_d   = mem_q[rd_ptr_q];
      bit_div_d = bit_div_new;
      timer_d   = bit_div_new - 16'd1;
      bit_cnt_d = 3'd0;
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end
  end

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  always_comb begin
    accept     = push_req && (!full || pop);
    wr_ptr_d   = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d    = count_q + CW'(accept) - CW'(pop);
    div_d      = div_wr ? write_data[15:0] : div_q;
    overflow_d = overflow_q;
    if (status_wr && write_data[3]) overflow_d = 1'b0;
    if (push_req && !accept)        overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      div_q      <= DEFAULT_DIV;
      bit_div_q  <= 16'd1;
      timer_q    <= 16'h0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h0;
      uart_tx_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      div_q      <= div_d;
      bit_div_q  <= bit_div_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      uart_tx_q  <= uart_tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= write_data[7:0];
  end

endmodule
